shift_add_multiplier: RTL and testbench

//   Parametrised iterative shift-and-add multiplier, one partial product per clock.

---
 rtl/shift_add_multiplier.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one partial product per clock, start/ready/done handshake, synchronous abort.
// Optional two's-complement mode is enabled by defining SIGNED_MULT_EN, which adds the is_signed input.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
`ifdef SIGNED_MULT_EN
    input  logic                 is_signed,
`endif
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   q_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               ready_q;
    logic               done_q;
    logic               signed_q;

    logic [WIDTH:0]     acc_ext_d;
    logic [WIDTH:0]     a_ext_d;
    logic [WIDTH:0]     sum_d;
    logic               last_d;

    assign last_d = (cnt_q == CNT_W'(1));

    // In signed mode both addends are sign-extended so the (WIDTH+1)-bit sum is exact,
    // and the final iteration weights B's sign bit negatively by subtracting A.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_ext_d = {1'b0, acc_q};
        a_ext_d   = {1'b0, a_q};
        if (signed_q) begin
            acc_ext_d = {acc_q[WIDTH-1], acc_q};
            a_ext_d   = {a_q[WIDTH-1], a_q};
        end
        sum_d = acc_ext_d;
        if (q_q[0]) begin
            if (signed_q && last_d) begin
                sum_d = acc_ext_d - a_ext_d;
            end else begin
                sum_d = acc_ext_d + a_ext_d;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            signed_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ready_q && start) begin
                        a_q      <= multiplicand;
                        q_q      <= multiplier;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
`ifdef SIGNED_MULT_EN
                        signed_q <= is_signed;
`else
                        signed_q <= 1'b0;
`endif
                        ready_q  <= 1'b0;
                        state_q  <= RUN;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= sum_d[WIDTH:1];
                        q_q   <= {sum_d[0], q_q[WIDTH-1:1]};
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (last_d) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // ready stays low through the done pulse and rises one edge later.
                    product_q <= {acc_q, q_q};
                    done_q    <= 1'b1;
                    ready_q   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign ready   = ready_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=4: latency, handshake, abort, async reset
// and, when SIGNED_MULT_EN is defined, two's-complement results.
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   multiplicand = '0;
    logic [2*W-1:0] product;
    logic           ready;
    logic           done;
`ifdef SIGNED_MULT_EN
    logic           is_signed = 1'b0;
`endif

    int n_errors = 0;
    int n_checks = 0;

    int             lat, low, nd, first, second;
    logic [2*W-1:0] pd, p1, p2;
    logic           r6, r7;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
`ifdef SIGNED_MULT_EN
        .is_signed    (is_signed),
`endif
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .ready        (ready),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues a one-cycle start, then watches from the cycle after the accepting edge (e=0)
    // until ready returns; lat is the first e at which done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ab,
                          output int o_lat, output int o_low, output int o_nd,
                          output logic [2*W-1:0] o_pd);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        abort        = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        o_lat = -1;
        o_low = 0;
        o_nd  = 0;
        o_pd  = '0;
        for (int e = 0; e <= 20; e++) begin
            if (!ready) o_low++;
            if (done) begin
                o_nd++;
                if (o_lat < 0) begin
                    o_lat = e;
                    o_pd  = product;
                end
            end
            if (ready) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_product", product, 0);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        rst = 1'b1;

        run_op(4'd13, 4'd11, 1'b0, lat, low, nd, pd);
        check("13x11_product", pd, 8'h8F);
        check("13x11_latency", lat, 5);
        check("13x11_ready_low", low, 6);
        check("13x11_done_count", nd, 1);

        run_op(4'd15, 4'd15, 1'b0, lat, low, nd, pd);
        check("15x15_product", pd, 8'hE1);
        check("15x15_latency", lat, 5);
        repeat (3) @(negedge clk);
        check("15x15_held", product, 8'hE1);
        check("idle_ready", ready, 1);

        // Abort raised in the third RUN cycle (the cycle after edge 2).
        @(negedge clk);
        multiplicand = 4'd5; multiplier = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort3_ready", ready, 1);
        check("abort3_done", done, 0);
        check("abort3_product", product, 8'hE1);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort3_no_done", nd, 0);

        // Abort coinciding with the final RUN cycle (the cycle after edge 3).
        @(negedge clk);
        multiplicand = 4'd7; multiplier = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_last_ready", ready, 1);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_last_no_done", nd, 0);
        check("abort_last_product", product, 8'hE1);

        // Zero operand, with abort asserted on the accepting edge (ignored in IDLE).
        run_op(4'd0, 4'd9, 1'b1, lat, low, nd, pd);
        check("0x9_product", pd, 8'h00);
        check("0x9_latency", lat, 5);
        check("0x9_ready_low", low, 6);

        // start held high: second op is accepted only once ready has returned.
        @(negedge clk);
        multiplicand = 4'd3; multiplier = 4'd5; start = 1'b1;
        @(negedge clk);
        multiplicand = 4'd2; multiplier = 4'd7;
        nd = 0; first = -1; second = -1; p1 = '0; p2 = '0; r6 = 1'b0; r7 = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            if (e == 6) r6 = ready;
            if (e == 7) r7 = ready;
            if (done) begin
                nd++;
                if (first < 0) begin
                    first = e; p1 = product;
                end else if (second < 0) begin
                    second = e; p2 = product;
                end
            end
            if (e == 7) start = 1'b0;
            @(negedge clk);
        end
        check("held_done_count", nd, 2);
        check("held_first_at", first, 5);
        check("held_first_product", p1, 8'h0F);
        check("held_ready_back", r6, 1);
        check("held_reaccept", r7, 0);
        check("held_second_at", second, 12);
        check("held_second_product", p2, 8'h0E);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        multiplicand = 4'd13; multiplier = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_product", product, 0);
        check("async_rst_ready", ready, 1);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(4'd7, 4'd6, 1'b0, lat, low, nd, pd);
        check("post_rst_product", pd, 8'h2A);
        check("post_rst_latency", lat, 5);

`ifdef SIGNED_MULT_EN
        is_signed = 1'b1;
        run_op(4'hD, 4'h5, 1'b0, lat, low, nd, pd);
        check("signed_m3x5", pd, 8'hF1);
        check("signed_latency", lat, 5);
        run_op(4'h8, 4'h8, 1'b0, lat, low, nd, pd);
        check("signed_m8xm8", pd, 8'h40);
        is_signed = 1'b0;
        run_op(4'd13, 4'd11, 1'b0, lat, low, nd, pd);
        check("unsigned_mode_13x11", pd, 8'h8F);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
